// File: rtl/blink_scheduler.sv
// Shared status-LED blink scheduler: round-robin grant, k blinks of T on/T off, then a 4T dark gap.
// Optional macro BLINK_ABORT_EN: owner dropping req during ON/OFF cuts straight to GAP.
module blink_scheduler #(
  parameter int NREQ   = 4,
  parameter int TICK_W = 22,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] code,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  led
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t            state, state_n;
  logic [TICK_W-1:0] presc;
  logic [1:0]        gap_units;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [IW-1:0]     last_grant, last_grant_n;
  logic [NREQ-1:0]   grant_n;
  logic [IW-1:0]     sel;
  logic              sel_valid;
  logic [IW:0]       sum;
  logic [CNT_W-1:0]  sel_code;
  logic              tick;

  assign tick = &presc;

  // Walk candidates from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    sel       = last_grant;
    sel_valid = 1'b0;
    sum       = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      sum = {1'b0, last_grant} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req[i] && sum == (IW+1)'(i)) begin
          sel       = IW'(i);
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == IW'(i))
        sel_code = code[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    last_grant_n = last_grant;
    grant_n      = grant;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          state_n      = ON;
          grant_n      = NREQ'(1) << sel;
          last_grant_n = sel;
          remaining_n  = (sel_code == '0) ? CNT_W'(1) : sel_code;
        end
      end
      ON: begin
        if (tick)
          state_n = OFF;
      end
      OFF: begin
        if (tick) begin
          remaining_n = remaining - 1'b1;
          state_n     = (remaining_n != '0) ? ON : GAP;
        end
      end
      GAP: begin
        if (tick && gap_units == 2'd3) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef BLINK_ABORT_EN
    if ((state == ON || state == OFF) && (req & grant) == '0) begin
      state_n     = GAP;
      remaining_n = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      gap_units  <= '0;
      remaining  <= '0;
      last_grant <= IW'(NREQ-1);
      grant      <= '0;
      busy       <= 1'b0;
      led        <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      busy       <= (state_n != IDLE);
      led        <= (state_n == ON);
      // The prescaler restarts on every state change so each unit is exactly 2^TICK_W cycles.
      if (state_n != state) begin
        presc     <= '0;
        gap_units <= '0;
      end else begin
        presc <= presc + 1'b1;
        if (state == GAP && tick)
          gap_units <= gap_units + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Self-checking bench for blink_scheduler at NREQ=4, TICK_W=3 (T=8), CNT_W=4.
// Define BLINK_ABORT_EN for both bench and RTL to exercise the abort variant.
module tb_blink_scheduler;

  localparam int NREQ   = 4;
  localparam int TICK_W = 3;
  localparam int CNT_W  = 4;
  localparam int T      = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] code;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  exp_grant;
    int          exp_k;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    int         k;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  blink_scheduler #(.NREQ(NREQ), .TICK_W(TICK_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .code  (code),
    .grant (grant),
    .busy  (busy),
    .led   (led)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk({name, "_start_timeout"}, 0, 1);
  endtask

  // Pops the expected sequence and follows it cycle by cycle until busy drops.
  task automatic observe(input string name);
    exp_t e;
    int   nb = 0;
    int   nled = 0;
    int   ng = 0;
    logic exp_led;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    while (busy && nb < 400) begin
      nb++;
      exp_led = (nb <= 2*T*e.k) && ((((nb-1)/T) % 2) == 0);
      if (led !== exp_led) nled++;
      if (grant !== e.grant) ng++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, nb, (2*e.k + 4)*T);
    chk({name, "_led_pattern_errs"}, nled, 0);
    chk({name, "_grant_errs"}, ng, 0);
    chk({name, "_idle_grant"}, int'(grant), 0);
    chk({name, "_idle_led"}, int'(led), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    code  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int nled;
    int nidle;
    int nbad;

    vecs[0] = '{4'b0001, 16'h0003, 4'b0001, 3};
    vecs[1] = '{4'b0001, 16'h0000, 4'b0001, 1};
    vecs[2] = '{4'b1010, 16'h4020, 4'b0010, 2};
    vecs[3] = '{4'b1010, 16'h4020, 4'b1000, 4};
    vecs[4] = '{4'b0110, 16'h0210, 4'b0010, 1};
    vecs[5] = '{4'b0110, 16'h0210, 4'b0100, 2};

    reset = 1'b1;
    req   = '0;
    code  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_grant", int'(grant), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      code = vecs[i].code;
      sb.push_back('{vecs[i].exp_grant, vecs[i].exp_k});
      @(negedge clk);
      wait_busy($sformatf("vec%0d", i));
      observe($sformatf("vec%0d", i));
      req = '0;
    end

    // Everyone requesting with code 1: rotation with a single idle cycle between sequences.
    do_reset();
    code = 16'h1111;
    req  = 4'b1111;
    sb.push_back('{4'b0001, 1});
    sb.push_back('{4'b0010, 1});
    sb.push_back('{4'b0100, 1});
    sb.push_back('{4'b1000, 1});
    sb.push_back('{4'b0001, 1});
    @(negedge clk);
    wait_busy("rr");
    for (int i = 0; i < 5; i++) begin
      observe($sformatf("rr%0d", i));
      if (i < 4) begin
        nidle = 0;
        while (!busy && nidle < 10) begin
          nidle++;
          @(negedge clk);
        end
        chk($sformatf("rr_idle_gap%0d", i), nidle, 1);
      end
    end
    req = '0;

    // Mid-sequence code change and a req pulse from another requester are ignored.
    do_reset();
    code = 16'h0002;
    req  = 4'b0001;
    sb.push_back('{4'b0001, 2});
    @(negedge clk);
    wait_busy("ignore");
    fork
      observe("ignore");
      begin
        repeat (5) @(negedge clk);
        code = 16'h0777;
        req  = 4'b0101;
        @(negedge clk);
        req = 4'b0001;
      end
    join
    req  = '0;
    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant != '0 || busy) nbad++;
    end
    chk("pulse_never_granted", nbad, 0);

    // Reset during the second ON of a 5-blink sequence.
    do_reset();
    code = 16'h0105;
    req  = 4'b0001;
    @(negedge clk);
    wait_busy("rst_mid");
    repeat (19) @(negedge clk);
    chk("rst_mid_second_on_led", int'(led), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_led", int'(led), 0);
    chk("rst_mid_grant", int'(grant), 0);
    chk("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    req   = 4'b0100;
    sb.push_back('{4'b0100, 1});
    @(negedge clk);
    wait_busy("after_rst");
    observe("after_rst");
    req = '0;

    // Owner drops req during the first ON of a 5-blink sequence.
    do_reset();
    code = 16'h0005;
    req  = 4'b0001;
    @(negedge clk);
    wait_busy("drop");
    nb   = 0;
    nled = 0;
    while (busy && nb < 400) begin
      nb++;
      if (led) nled++;
      if (nb == 3) req = '0;
      @(negedge clk);
    end
`ifdef BLINK_ABORT_EN
    chk("drop_busy_cycles", nb, 3 + 4*T);
    chk("drop_led_cycles", nled, 3);
`else
    chk("drop_busy_cycles", nb, (2*5 + 4)*T);
    chk("drop_led_cycles", nled, 5*T);
`endif
    chk("drop_idle_grant", int'(grant), 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of status requesters sharing the LED, range 2..8.
REQ-002 Parameter TICK_W, default 22: blink unit period T = 2^TICK_W clk cycles, range 2..26.
REQ-003 Parameter CNT_W, default 4: width of each requester's blink-count code.
REQ-004 Port clk  input  1: single clock; all logic on posedge clk.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port req  input  NREQ: level request per requester; bit i = requester i wants the LED.
REQ-007 Port code  input  NREQ*CNT_W: blink count for requester i in bits [i*CNT_W +: CNT_W].
REQ-008 Port grant  output  NREQ: one-hot owner of the current sequence; all-zero when idle.
REQ-009 Port busy  output  1: high while a sequence is in progress (any non-IDLE state).
REQ-010 Port led  output  1: registered LED drive, 1 = lit.

Function
REQ-011 States SHALL be IDLE, ON, OFF and GAP, held in one registered FSM.
REQ-012 A TICK_W-bit prescaler SHALL count every cycle and be cleared on every state change, so each ON, OFF and GAP unit lasts exactly T cycles.
REQ-013 In IDLE with req != 0 sampled at cycle n, the FSM SHALL enter ON at n+1 with led=1, busy=1 and grant one-hot to the selected requester.
REQ-014 Selection SHALL be round-robin: the lowest-cost index searching upward (mod NREQ) from last_grant+1; after reset last_grant = NREQ-1, so requester 0 wins first.
REQ-015 On grant, the requester's code SHALL be latched into remaining; code 0 SHALL be treated as 1; later code changes have no effect on the running sequence.
REQ-016 ON SHALL last T cycles, then go to OFF (led=0) for T cycles, then decrement remaining.
REQ-017 After OFF, if remaining (post-decrement) != 0 the FSM SHALL return to ON; otherwise it SHALL go to GAP.
REQ-018 GAP SHALL last 4T cycles with led=0 and grant held, then go to IDLE with grant=0 and busy=0 for at least one cycle before the next grant.
REQ-019 A sequence of count k SHALL occupy exactly 2kT + 4T cycles from first led=1 to entry into IDLE.
REQ-020 Requests SHALL NOT be queued; a requester must hold req high until granted, and a req pulse seen only outside IDLE is lost.
REQ-021 Requests arriving while busy SHALL NOT alter grant or timing.
REQ-022 Simultaneous requests in IDLE SHALL resolve by REQ-014 in the same cycle; no idle cycles are inserted.
REQ-023 led SHALL be high only in ON; grant SHALL never have more than one bit set.

Reset
REQ-024 While reset is high on a clk edge: state=IDLE, prescaler=0, remaining=0, last_grant=NREQ-1, led=0, busy=0, grant=0.
REQ-025 Reset asserted mid-sequence SHALL abort it at the next edge with no further LED pulse; the first grant after reset follows REQ-014.

Configuration
REQ-026 Macro BLINK_ABORT_EN: when defined, deassertion of req by the granted requester in ON or OFF SHALL force the FSM to GAP on the next cycle (led=0, prescaler cleared, remaining cleared).
REQ-027 Without BLINK_ABORT_EN, a started sequence SHALL always run to completion regardless of req (REQ-016..018).

Verification (TICK_W=3, T=8, NREQ=4, CNT_W=4)
REQ-028 Reset release, req=0001, code0=3 -> led high at cycles 1-8, 17-24 and 33-40 after grant; grant=0001; IDLE reached 80 cycles after grant.
REQ-029 req=1111 held, all codes=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each sequence 48 cycles, busy low for exactly 1 cycle between them.
REQ-030 code0=0 -> exactly one 8-cycle led pulse followed by a 40-cycle dark period.
REQ-031 code changed and req pulsed on another requester mid-sequence -> the running blink count is unchanged, and the pulsed requester is never granted.
REQ-032 Reset asserted during the second ON of a 5-blink sequence -> led=0, grant=0, busy=0 next cycle; the next req=0100 grants 0100.
REQ-033 With BLINK_ABORT_EN, req0 dropped during the first ON of code=5 -> GAP next cycle, led=0 for 32 cycles, then IDLE; without the macro all 5 blinks complete.
